lidar_crc_appender: RTL and testbench

//  Transmit-side counterpart of the bitstream-reader CRC check in the LiDAR decoder path.

---
 rtl/lidar_crc_pkg.sv | 20 ++
 rtl/lidar_crc32_byte_step.sv | 15 +
 rtl/lidar_crc_appender.sv | 144 ++++++++++++++
 tb/tb_lidar_crc_appender.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lidar_crc_pkg.sv
// Shared CRC-32 (IEEE 802.3, reflected) definitions for the LiDAR transmit and receive paths.
package lidar_crc_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

  typedef enum logic {ST_DATA, ST_CRC} crc_tx_state_t;

  // Advance a reflected CRC-32 register by one byte, LSB first.
  function automatic logic [31:0] crc32_step_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/lidar_crc32_byte_step.sv
// Combinational single-byte CRC-32 step around the package function.
module lidar_crc32_byte_step
  import lidar_crc_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_c_o
);

  // Pure function of the current register and the incoming byte.
  always_comb begin
    crc_c_o = crc32_step_byte(crc_i, data_i);
  end

endmodule

// File: rtl/lidar_crc_appender.sv
// Forwards a framed byte stream and appends its CRC-32, LSB first, after each frame.
// Optional build macro LIDAR_CRC_FRAME_CNT_EN adds a 16-bit count of completed frames.
module lidar_crc_appender
  import lidar_crc_pkg::*;
#(
  parameter int unsigned MAX_FRAME_BYTES = 64,
  parameter logic [31:0] CRC_INIT        = CRC32_INIT,
  parameter logic [31:0] CRC_XOROUT      = CRC32_XOROUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       err_oversize
`ifdef LIDAR_CRC_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_FRAME_BYTES + 2);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_FRAME_BYTES);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_FRAME_BYTES + 1);

  crc_tx_state_t    state_q;
  logic [31:0]      crc_q;
  logic [31:0]      crc_out_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic [1:0]       idx_q;
  logic [7:0]       out_data_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             err_q;

  logic [31:0]      crc_step;
  logic             out_free;
  logic             accept;
  logic [7:0]       crc_byte;

  lidar_crc32_byte_step u_step (
    .crc_i   (crc_q),
    .data_i  (in_data),
    .crc_c_o (crc_step)
  );

  // Holding register is free when empty or being drained this cycle.
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == ST_DATA) && out_free;
  assign accept   = in_valid && in_ready;

  // Select the trailer byte to emit, LSB first.
  always_comb begin
    crc_byte = crc_out_q[7:0];
    case (idx_q)
      2'd0: crc_byte = crc_out_q[7:0];
      2'd1: crc_byte = crc_out_q[15:8];
      2'd2: crc_byte = crc_out_q[23:16];
      2'd3: crc_byte = crc_out_q[31:24];
      default: crc_byte = crc_out_q[7:0];
    endcase
  end

  // Framing FSM, running CRC, size counter and output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_DATA;
      crc_q       <= CRC_INIT;
      crc_out_q   <= 32'h0;
      byte_cnt_q  <= '0;
      idx_q       <= 2'd0;
      out_data_q  <= 8'h0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ST_DATA: begin
          if (accept) begin
            out_data_q  <= in_data;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            crc_q       <= crc_step;
            if (byte_cnt_q == CNT_LIMIT) begin
              err_q <= 1'b1;
            end
            if (byte_cnt_q != CNT_SAT) begin
              byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end
            if (in_last) begin
              crc_out_q <= crc_step ^ CRC_XOROUT;
              idx_q     <= 2'd0;
              state_q   <= ST_CRC;
            end
          end
        end
        ST_CRC: begin
          if (out_free) begin
            out_data_q  <= crc_byte;
            out_valid_q <= 1'b1;
            out_last_q  <= (idx_q == 2'd3);
            idx_q       <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              crc_q      <= CRC_INIT;
              byte_cnt_q <= '0;
              state_q    <= ST_DATA;
            end
          end
        end
        default: state_q <= ST_DATA;
      endcase
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign err_oversize = err_q;

`ifdef LIDAR_CRC_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Count frames whose final trailer byte has been taken downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 16'h0;
    end else if (out_valid_q && out_ready && out_last_q) begin
      frame_cnt_q <= frame_cnt_q + 16'h1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_lidar_crc_appender.sv
// Scoreboard bench for lidar_crc_appender with an independent CRC-32 reference.
module tb_lidar_crc_appender;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } item_t;
  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       busy;  // block must be refusing input while this byte is presented
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       err_oversize;
`ifdef LIDAR_CRC_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  lidar_crc_appender dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .err_oversize (err_oversize)
`ifdef LIDAR_CRC_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   frame_acc = 0;
  int   err_pulses = 0;
  int   frames_done = 0;
  bit   rand_ready = 1'b0;
  int   first_acc_cyc = 0;
  int   last_acc_cyc = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] b);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = b[31-i];
    return r;
  endfunction

  // Normal-form CRC-32 (poly 04C11DB7, MSB first) on bit-reversed bytes, result reflected.
  function automatic logic [31:0] ref_crc(input byte_q_t d);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    foreach (d[k]) begin
      r = r ^ {rev8(d[k]), 24'h0};
      for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    end
    return rev32(r) ^ 32'hFFFFFFFF;
  endfunction

  // Expected output stream: payload unchanged, then 4 CRC bytes LSB first.
  task automatic push_frame(input byte_q_t p, input logic [31:0] crc, input bit trailer);
    logic [31:0] c;
    c = crc;
    foreach (p[k]) sb.push_back('{p[k], 1'b0, trailer && (k == p.size() - 1)});
    if (trailer) begin
      for (int i = 0; i < 4; i++) begin
        sb.push_back('{c[7:0], i == 3, i < 3});
        c = c >> 8;
      end
    end
  endtask

  function automatic void add_items(inout item_t it[$], input byte_q_t p, input bit closed);
    foreach (p[k]) it.push_back('{p[k], closed && (k == p.size() - 1)});
  endfunction

  // Present items back to back; in_valid stays high across frame boundaries.
  task automatic drive(input item_t it[$]);
    bit acc;
    int n;
    bit new_frame;
    new_frame = 1'b1;
    foreach (it[k]) begin
      in_valid = 1'b1;
      in_data  = it[k].data;
      in_last  = it[k].last;
      acc = 1'b0;
      n = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        n++;
        if (!acc && n > 1000) begin
          check("accept_timeout", 32'(n), 32'd0);
          in_valid = 1'b0;
          return;
        end
      end
      if (new_frame) frame_acc = 0;
      frame_acc++;
      new_frame = it[k].last;
      if (k == 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_err"}, 32'(err_oversize), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // Output ready pattern: constant 1 or a 50% random toggle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pop and compare on each output transfer; check stall stability.
  initial begin
    exp_t e;
    bit   stalled;
    logic [8:0] held;
    stalled = 1'b0;
    held = 9'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        stalled = 1'b0;
      end else begin
        if (stalled && out_valid) check("stall_hold", {23'h0, out_data, out_last}, {23'h0, held});
        if (err_oversize) begin
          err_pulses++;
          check("oversize_byte_index", 32'(frame_acc), 32'd65);
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_output", {24'h0, out_data}, 32'hFFFFFFFF);
          end else begin
            e = sb[0];
            if (e.busy) check("in_ready_low_crc", 32'(in_ready), 32'd0);
            if (out_ready) begin
              void'(sb.pop_front());
              check("out_data", {24'h0, out_data}, {24'h0, e.data});
              check("out_last", 32'(out_last), 32'(e.last));
              if (e.last) frames_done++;
            end
          end
        end
        stalled = out_valid && !out_ready;
        held = {out_data, out_last};
      end
    end
  end

  initial begin
    byte_q_t t1, t2, pr, p;
    item_t   it[$];
    for (int i = 0; i < 9; i++) t1.push_back(8'(8'h31 + i));
    t2.push_back(8'h00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T1 and T2 against the published trailers
    push_frame(t1, 32'hCBF43926, 1'b1);
    it.delete(); add_items(it, t1, 1'b1); drive(it);
    wait_drain();
    push_frame(t2, 32'hD202EF8D, 1'b1);
    it.delete(); add_items(it, t2, 1'b1); drive(it);
    wait_drain();

    // T3 T1 with random backpressure
    rand_ready = 1'b1;
    push_frame(t1, 32'hCBF43926, 1'b1);
    it.delete(); add_items(it, t1, 1'b1); drive(it);
    wait_drain();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // T4 back-to-back frames: 19 payload bytes plus two 4-cycle trailer gaps
    push_frame(t1, ref_crc(t1), 1'b1);
    push_frame(t2, ref_crc(t2), 1'b1);
    push_frame(t1, ref_crc(t1), 1'b1);
    it.delete(); add_items(it, t1, 1'b1); add_items(it, t2, 1'b1); add_items(it, t1, 1'b1);
    drive(it);
    check("b2b_accept_span", 32'(last_acc_cyc - first_acc_cyc), 32'd26);
    wait_drain();

    // T5 reset after five bytes of T1, then T2
    pr.delete();
    for (int i = 0; i < 5; i++) pr.push_back(t1[i]);
    push_frame(pr, 32'h0, 1'b0);
    it.delete(); add_items(it, pr, 1'b0); drive(it);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    frames_done = 0;
    push_frame(t2, 32'hD202EF8D, 1'b1);
    it.delete(); add_items(it, t2, 1'b1); drive(it);
    wait_drain();

    // T6 oversize 70-byte frame
    p.delete();
    for (int i = 0; i < 70; i++) p.push_back(8'hA5);
    push_frame(p, ref_crc(p), 1'b1);
    it.delete(); add_items(it, p, 1'b1); drive(it);
    wait_drain();
    check("oversize_pulse_count", 32'(err_pulses), 32'd1);

    // Random frames under random backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      p.delete();
      for (int i = 0; i < int'($urandom_range(1, 24)); i++) p.push_back(8'($urandom));
      push_frame(p, ref_crc(p), 1'b1);
      it.delete(); add_items(it, p, 1'b1); drive(it);
    end
    wait_drain();
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("oversize_pulse_total", 32'(err_pulses), 32'd1);
    check("frames_after_reset", 32'(frames_done), 32'd10);
`ifdef LIDAR_CRC_FRAME_CNT_EN
    check("frame_cnt", 32'(frame_cnt), 32'(frames_done));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
